// File: rtl/rot_cmd_seq_if.sv
// Command and rotator-drive bundle between a command source and rot_cmd_seq.
// The slave side is the sequencer; the master side is whoever issues commands.
interface rot_cmd_seq_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [6:0]  cmd_count;
    logic [99:0] cmd_data;
    logic        load;
    logic [1:0]  ena;
    logic [99:0] data;
    logic        busy;
    logic        done;

    modport slave (
        input  cmd_valid, cmd_op, cmd_count, cmd_data,
        output cmd_ready, load, ena, data, busy, done
    );

    modport master (
        output cmd_valid, cmd_op, cmd_count, cmd_data,
        input  cmd_ready, load, ena, data, busy, done
    );
endinterface

// File: rtl/rot_cmd_seq.sv
// Command sequencer for a 100-bit rotator: 4-deep command FIFO feeding an FSM
// that drives registered load/ena/data with back-to-back command chaining.
module rot_cmd_seq (
    input  logic          clk,
    input  logic          areset,
    rot_cmd_seq_if.slave  bus
);
    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_ROTR = 2'b01;
    localparam logic [1:0] OP_ROTL = 2'b10;
    localparam int         DEPTH   = 4;

    typedef struct packed {
        logic [1:0]  op;
        logic [6:0]  count;
        logic [99:0] data;
    } cmd_t;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ROT, S_WAIT} state_t;

    cmd_t        mem_q [DEPTH];
    logic [1:0]  wr_ptr_q, rd_ptr_q;
    logic [2:0]  occ_q;

    state_t      state_q;
    logic [6:0]  cnt_q;
    logic        load_q;
    logic [1:0]  ena_q;
    logic [99:0] data_q;
    logic        done_q;

    logic        push, pop, last_cycle;
    cmd_t        head;

    assign head       = mem_q[rd_ptr_q];
    assign push       = bus.cmd_valid && bus.cmd_ready;
    assign last_cycle = (state_q == S_LOAD) ||
                        (((state_q == S_ROT) || (state_q == S_WAIT)) && (cnt_q == 7'd0));
    // Popping on the final cycle of a command is what removes the bubble between commands.
    assign pop        = (occ_q != 3'd0) && ((state_q == S_IDLE) || last_cycle);

    assign bus.cmd_ready = (occ_q < 3'(DEPTH));
    assign bus.busy      = (state_q != S_IDLE) || (occ_q != 3'd0);
    assign bus.load      = load_q;
    assign bus.ena       = ena_q;
    assign bus.data      = data_q;
    assign bus.done      = done_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{op: bus.cmd_op, count: bus.cmd_count, data: bus.cmd_data};
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            occ_q    <= 3'd0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
            case ({push, pop})
                2'b10:   occ_q <= occ_q + 3'd1;
                2'b01:   occ_q <= occ_q - 3'd1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q <= S_IDLE;
            cnt_q   <= 7'd0;
            load_q  <= 1'b0;
            ena_q   <= 2'b00;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            load_q <= 1'b0;
            done_q <= 1'b0;
            if (pop) begin
                if (head.op == OP_LOAD) begin
                    state_q <= S_LOAD;
                    cnt_q   <= 7'd0;
                    load_q  <= 1'b1;
                    ena_q   <= 2'b00;
                    data_q  <= head.data;
                    done_q  <= 1'b1;
                end else begin
                    // A zero count still takes one cycle, run as a hold.
                    cnt_q  <= (head.count == 7'd0) ? 7'd0 : head.count - 7'd1;
                    done_q <= (head.count <= 7'd1);
                    if ((head.op == OP_ROTR || head.op == OP_ROTL) && head.count != 7'd0) begin
                        state_q <= S_ROT;
                        ena_q   <= (head.op == OP_ROTR) ? 2'b01 : 2'b10;
                    end else begin
                        state_q <= S_WAIT;
                        ena_q   <= 2'b00;
                    end
                end
            end else if (last_cycle || state_q == S_IDLE) begin
                state_q <= S_IDLE;
                ena_q   <= 2'b00;
            end else begin
                cnt_q  <= cnt_q - 7'd1;
                done_q <= (cnt_q == 7'd1);
            end
        end
    end
endmodule

// File: doc/rot_cmd_seq.md
ROT_CMD_SEQ -- requirements
Module: rot_cmd_seq

Interface
REQ-001 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-002 SHALL have port: areset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: cmd_valid  input  1  command present on cmd_* this cycle.
REQ-004 SHALL have port: cmd_ready  output  1  command FIFO can accept (not full).
REQ-005 SHALL have port: cmd_op  input  2  00 LOAD, 01 ROTR, 10 ROTL, 11 WAIT.
REQ-006 SHALL have port: cmd_count  input  7  cycle count for ROTR/ROTL/WAIT; ignored for LOAD.
REQ-007 SHALL have port: cmd_data  input  100  load value for LOAD; ignored otherwise.
REQ-008 SHALL have port: load  output  1  to rotator load.
REQ-009 SHALL have port: ena  output  2  to rotator ena: 01 right, 10 left, 00 hold.
REQ-010 SHALL have port: data  output  100  to rotator data.
REQ-011 SHALL have port: busy  output  1  FSM not IDLE or FIFO non-empty.
REQ-012 SHALL have port: done  output  1  one-cycle pulse on final output cycle of each command.
REQ-013 SHALL have one clock, clk; reset areset SHALL be asynchronous and active-high.

Function
REQ-014 SHALL buffer commands in a 4-entry FIFO; push on rising edge when cmd_valid && cmd_ready.
REQ-015 cmd_ready SHALL be registered-state derived: 1 iff FIFO occupancy < 4; no combinational path from cmd_valid.
REQ-016 FSM states SHALL be IDLE, LOAD, ROT, WAIT.
REQ-017 In IDLE with FIFO non-empty, SHALL pop head on the edge and enter the state for its op; load/ena/data registered, valid from that edge.
REQ-018 Latency: command pushed at edge N into empty FIFO with FSM IDLE SHALL drive outputs in the cycle after edge N+1.
REQ-019 LOAD SHALL last exactly 1 cycle: load=1, ena=00, data=cmd_data, done=1.
REQ-020 ROTR/ROTL SHALL last cmd_count cycles: load=0, ena=01/10, done=1 in the last cycle only.
REQ-021 WAIT SHALL last cmd_count cycles with load=0, ena=00, done=1 in the last cycle.
REQ-022 cmd_count=0 for ROTR/ROTL/WAIT SHALL occupy 1 cycle with load=0, ena=00, done=1.
REQ-023 On a command's final cycle with FIFO non-empty, SHALL pop next command on same edge: zero bubble between commands.
REQ-024 On final cycle with FIFO empty, SHALL return to IDLE: load=0, ena=00, done=0.
REQ-025 data SHALL hold the most recently loaded value at all times outside LOAD.
REQ-026 Push and pop on same edge SHALL both take effect; occupancy unchanged.
REQ-027 Push when full SHALL be impossible (cmd_ready=0); cmd_valid with cmd_ready=0 SHALL be ignored, no state change.
REQ-028 Cycle counter SHALL be 7 bits, load cmd_count-1, decrement to 0; no wrap.
REQ-029 load and ena SHALL never both be non-zero in the same cycle.

Reset
REQ-030 areset=1 SHALL immediately, without clock: FSM=IDLE, FIFO empty, load=0, ena=00, data=0, done=0, busy=0, cmd_ready=1.
REQ-031 Reset asserted mid-command SHALL abort it and discard all queued commands; no done pulse.
REQ-032 After deassertion, first push SHALL follow REQ-018 latency.

Verification
REQ-033 Push LOAD data=1 into idle block -> 2 edges later load=1, data=1, done=1 for 1 cycle; next cycle load=0, busy=0.
REQ-034 Push LOAD 1, ROTR 3, ROTL 2 back-to-back -> outputs load 1 cycle, ena=01 3 cycles, ena=10 2 cycles, no gaps; done on cycles 1, 4, 6; attached rotator q = 1, then bit 97 set.
REQ-035 Hold cmd_valid=1 with WAIT 10 continuously -> cmd_ready drops after 5 accepted (4 queued + 1 popped); rises 1 cycle after each pop.
REQ-036 Push ROTL count=0 -> one cycle ena=00, done=1; then IDLE.
REQ-037 Assert areset during cycle 2 of ROTR 5 with 2 queued -> same cycle ena=00, busy=0, cmd_ready=1; no further output activity.
REQ-038 Push ROTR 127 -> exactly 127 cycles of ena=01, done only on the 127th.
